// File: rtl/register_file_param.sv
// Two-read/one-write register file, DEPTH = 2**ADDR_W entries of DATA_W bits; optional ZERO_REG_EN hardwires entry DEPTH-1 to zero.
// Latency: writes land on the clock edge; reads are registered with 1-cycle latency and same-edge write-through bypass.
// Backpressure: none; every enabled read or write completes on its edge, and R_Valid_X is R_En_X delayed one cycle.
module register_file_param #(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 3,
  localparam int DEPTH  = 2**ADDR_W
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              W_En,
  input  logic [ADDR_W-1:0] W_Addr,
  input  logic [DATA_W-1:0] W_Data,
  input  logic              R_En_A,
  input  logic [ADDR_W-1:0] R_Addr_A,
  output logic [DATA_W-1:0] R_Data_A,
  output logic              R_Valid_A,
  input  logic              R_En_B,
  input  logic [ADDR_W-1:0] R_Addr_B,
  output logic [DATA_W-1:0] R_Data_B,
  output logic              R_Valid_B
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_data_a;
  logic [DATA_W-1:0] r_data_b;
  logic              r_valid_a;
  logic              r_valid_b;

  logic              w_wr_ok;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;

`ifdef ZERO_REG_EN
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // The last entry is a constant zero: writes to it are dropped, so it never leaves its reset value.
  assign w_wr_ok = W_En && (W_Addr != LAST_ADDR);

  // Read mux with bypass; the last entry is forced to zero explicitly so bypass cannot leak data into it.
  always_comb begin
    w_rd_a = '0;
    w_rd_b = '0;
    if (R_Addr_A != LAST_ADDR) begin
      w_rd_a = (w_wr_ok && (W_Addr == R_Addr_A)) ? W_Data : r_mem[R_Addr_A];
    end
    if (R_Addr_B != LAST_ADDR) begin
      w_rd_b = (w_wr_ok && (W_Addr == R_Addr_B)) ? W_Data : r_mem[R_Addr_B];
    end
  end
`else
  assign w_wr_ok = W_En;

  // Read mux with write-through bypass so a same-edge write is visible to the read.
  always_comb begin
    w_rd_a = (w_wr_ok && (W_Addr == R_Addr_A)) ? W_Data : r_mem[R_Addr_A];
    w_rd_b = (w_wr_ok && (W_Addr == R_Addr_B)) ? W_Data : r_mem[R_Addr_B];
  end
`endif

  // Storage update; reset clears every entry so post-reset reads return zero until written.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_mem[W_Addr] <= W_Data;
    end
  end

  // Port A read register: data loads only on enable and otherwise holds; valid tracks enable.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_data_a  <= '0;
      r_valid_a <= 1'b0;
    end else begin
      r_valid_a <= R_En_A;
      if (R_En_A) begin
        r_data_a <= w_rd_a;
      end
    end
  end

  // Port B read register, independent of port A.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_data_b  <= '0;
      r_valid_b <= 1'b0;
    end else begin
      r_valid_b <= R_En_B;
      if (R_En_B) begin
        r_data_b <= w_rd_b;
      end
    end
  end

  assign R_Data_A  = r_data_a;
  assign R_Valid_A = r_valid_a;
  assign R_Data_B  = r_data_b;
  assign R_Valid_B = r_valid_b;

endmodule

// File: doc/register_file_param.md
REGISTER_FILE_PARAM -- requirements
Module: register_file_param

Interface
REQ-001 Parameter DATA_W, default 32, width of each register entry and of all data ports.
REQ-002 Parameter ADDR_W, default 3, address width; depth DEPTH = 2**ADDR_W entries (default 8), derived and not separately settable.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Rst  input  1  reset, asynchronous, active-low.
REQ-005 W_En  input  1  write enable.
REQ-006 W_Addr  input  ADDR_W  write address.
REQ-007 W_Data  input  DATA_W  write data.
REQ-008 R_En_A  input  1  read enable, port A.
REQ-009 R_Addr_A  input  ADDR_W  read address, port A.
REQ-010 R_Data_A  output  DATA_W  registered read data, port A.
REQ-011 R_Valid_A  output  1  port A data valid strobe.
REQ-012 R_En_B, R_Addr_B, R_Data_B, R_Valid_B SHALL mirror REQ-008..011 for independent port B.

Function
REQ-013 Storage SHALL be DEPTH entries of DATA_W bits; every address is legal, no out-of-range case.
REQ-014 On rising Clk with W_En=1, entry W_Addr SHALL take W_Data; W_En=0 leaves all entries unchanged.
REQ-015 Reads SHALL be registered, latency 1: on rising Clk with R_En_X=1, R_Data_X <= entry R_Addr_X and R_Valid_X <= 1.
REQ-016 On rising Clk with R_En_X=0, R_Data_X SHALL hold its previous value and R_Valid_X <= 0.
REQ-017 Write-through bypass: same edge with W_En=1, R_En_X=1, W_Addr==R_Addr_X SHALL load R_Data_X with W_Data (new value), not the old entry.
REQ-018 Ports A and B SHALL operate independently; both reading one address on one edge SHALL return identical data.
REQ-019 Consecutive writes to one address SHALL leave the last written value; no write is dropped or merged.
REQ-020 R_Valid_X SHALL be a pure one-cycle-delayed copy of R_En_X (outside reset); no other handshake.

Reset
REQ-021 Rst=0 SHALL immediately, without Clk, clear all entries, R_Data_A, R_Data_B to 0 and R_Valid_A, R_Valid_B to 0.
REQ-022 While Rst=0, writes and reads SHALL be ignored and outputs held at reset values.
REQ-023 After Rst rises, the first rising Clk SHALL perform normal write/read operation.
REQ-024 Reset asserted mid-operation SHALL discard any in-flight read result; post-reset reads of any address return 0 until written.

Configuration
REQ-025 Macro ZERO_REG_EN: when defined, entry DEPTH-1 SHALL read as 0 on both ports, writes to it SHALL be discarded, and bypass to it SHALL return 0.
REQ-026 Without ZERO_REG_EN, entry DEPTH-1 SHALL behave as an ordinary register.

Verification (DATA_W=32, ADDR_W=3)
REQ-027 Reset then write 33->0, 321->2, 111->3, 666->5; read A=2, B=5 -> next edge R_Data_A=321, R_Data_B=666, both valid=1.
REQ-028 W_En=0, W_Addr=7, W_Data=23; then read 7 -> R_Data=0 (entry untouched).
REQ-029 Same edge W_En=1, W_Addr=4, W_Data=0xDEADBEEF, R_En_A=1, R_Addr_A=4 -> R_Data_A=0xDEADBEEF after that edge.
REQ-030 Read A=3 (111), then R_En_A=0 for 3 cycles -> R_Data_A stays 111, R_Valid_A=0 each cycle.
REQ-031 Write 0x55 to 7 -> without ZERO_REG_EN read 7 returns 0x55; with ZERO_REG_EN returns 0, including same-edge bypass.
REQ-032 Pull Rst low mid-cycle after writes -> outputs 0 immediately without clock edge; after release, read 0 and 2 -> both 0.
